// File: rtl/vram_arbiter.sv
// vram_arbiter
//    Shares one single-port, synchronous-read video RAM between the VGA
//    scanout and a buffered CPU write port. Display reads on active pixel
//    strobes always win the bus. Queued CPU writes drain in every other
//    cycle. Scanned-out pixels come back with a fixed 3-cycle latency.
//
// Ports
//    in_clock, in_reset            clock, synchronous active-high reset
//    in_pixel_stb, in_active       pixel tick and active-area flag
//    in_x, in_y                    active-area column / row
//    in_wr_valid, out_wr_ready     CPU write handshake
//    in_wr_addr, in_wr_data        CPU write address / data
//    out_mem_addr, out_mem_we,
//    out_mem_wdata                 registered RAM command
//    in_mem_rdata                  RAM read data, one cycle after the address
//    out_pixel, out_pixel_valid    scanned-out pixel, 0 for blanking strobes
//    out_wr_drop                   pulse when an out-of-range write is discarded
module vram_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              in_clock,
   input  logic              in_reset,
   input  logic              in_pixel_stb,
   input  logic              in_active,
   input  logic [9:0]        in_x,
   input  logic [8:0]        in_y,
   input  logic              in_wr_valid,
   output logic              out_wr_ready,
   input  logic [ADDR_W-1:0] in_wr_addr,
   input  logic [DATA_W-1:0] in_wr_data,
   output logic [ADDR_W-1:0] out_mem_addr,
   output logic              out_mem_we,
   output logic [DATA_W-1:0] out_mem_wdata,
   input  logic [DATA_W-1:0] in_mem_rdata,
   output logic [DATA_W-1:0] out_pixel,
   output logic              out_pixel_valid,
   output logic              out_wr_drop
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(307200);

   logic [ADDR_W-1:0] queue_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] queue_data [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       count;

   logic              full;
   logic              push;
   logic              pop;
   logic              read_req;
   logic [ADDR_W-1:0] pixel_addr;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   // Two delay stages in front of the output register give the 3-cycle
   // strobe-to-pixel latency (address register, RAM read, output register).
   logic [1:0] pipe_valid;
   logic [1:0] pipe_blank;

   // y*640 + x as shifts and adds, so no multiplier is needed.
   assign pixel_addr = (ADDR_W'(in_y) << 9) + (ADDR_W'(in_y) << 7) + ADDR_W'(in_x);

   assign full         = (count == (PW+1)'(FIFO_DEPTH));
   assign out_wr_ready = !full && !in_reset;
   assign push         = in_wr_valid && out_wr_ready;
   assign read_req     = in_pixel_stb && in_active;
   // Pop only looks at entries already stored, so a write accepted this
   // cycle can never be issued before the following one.
   assign pop          = !read_req && (count != '0);
   assign head_addr    = queue_addr[rd_ptr];
   assign head_data    = queue_data[rd_ptr];

   // Queue storage is not reset; occupancy is governed by the pointers.
   always_ff @(posedge in_clock) begin
      if (push) begin
         queue_addr[wr_ptr] <= in_wr_addr;
         queue_data[wr_ptr] <= in_wr_data;
      end
   end

   // Queue pointers and occupancy; a simultaneous push and pop keeps the count.
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Bus arbitration: display read first, then a queued write, else idle.
   // Idle and discarded writes leave address and data where they were.
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         out_mem_addr  <= '0;
         out_mem_we    <= 1'b0;
         out_mem_wdata <= '0;
         out_wr_drop   <= 1'b0;
      end else begin
         out_mem_we  <= 1'b0;
         out_wr_drop <= 1'b0;
         if (read_req) begin
            out_mem_addr <= pixel_addr;
         end else if (pop) begin
            if (head_addr < FB_WORDS) begin
               out_mem_we    <= 1'b1;
               out_mem_addr  <= head_addr;
               out_mem_wdata <= head_data;
            end else begin
               out_wr_drop <= 1'b1;
            end
         end
      end
   end

   // Pixel return pipe: every strobe is tracked, blanking ones force zero.
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         pipe_valid      <= '0;
         pipe_blank      <= '0;
         out_pixel       <= '0;
         out_pixel_valid <= 1'b0;
      end else begin
         pipe_valid      <= {pipe_valid[0], in_pixel_stb};
         pipe_blank      <= {pipe_blank[0], !in_active};
         out_pixel_valid <= pipe_valid[1];
         out_pixel       <= (pipe_valid[1] && !pipe_blank[1]) ? in_mem_rdata : '0;
      end
   end

endmodule
